mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, >= 2.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 psel  input  1  peripheral selected (bus control drives pselect==2'b10); held stable until pready.
REQ-006 pwrite  input  1  1 = write, 0 = read; valid while psel=1.
REQ-007 paddr  input  4  byte offset within peripheral window; word aligned.
REQ-008 pwdata  input  32  write data.
REQ-009 prdata  output  32  read data; valid when pready=1.
REQ-010 pready  output  1  transfer complete; one-cycle pulse.
REQ-011 tx  output  1  serial line; idles high.

Function
REQ-012 Register map SHALL be: 0x0 TXDATA (write pushes pwdata[7:0]; read returns 0); 0x4 STATUS (read-only {29'b0, busy, empty, full}); other offsets ignore writes, read 0, still complete.
REQ-013 Bus FSM SHALL have states IDLE, ACCESS, DONE.
REQ-014 IDLE -> ACCESS on the cycle psel=1 is sampled; no pready in IDLE.
REQ-015 In ACCESS the block SHALL assert pready combinationally, perform the access and go to DONE; minimum latency is psel rise + 1 cycle.
REQ-016 Exception: write to TXDATA with FIFO full SHALL stay in ACCESS with pready=0 until a slot frees, then push and complete that cycle.
REQ-017 DONE SHALL return to IDLE only when psel=0, so one held psel yields exactly one push.
REQ-018 FIFO: full = count==FIFO_DEPTH, empty = count==0; pointers wrap modulo FIFO_DEPTH; push and pop in the same cycle leave count unchanged.
REQ-019 Full is sampled before the same-cycle pop; a stalled write completes the cycle after the pop.
REQ-020 Serializer states TX_IDLE, START, DATA, STOP; each bit lasts exactly CLK_DIV cycles from a counter reloaded at each bit boundary.
REQ-021 TX_IDLE with FIFO non-empty SHALL pop the head and enter START next cycle; tx=0 in START.
REQ-022 DATA SHALL send 8 bits LSB first; STOP drives tx=1 for one bit, then pops the next byte without an idle bit if the FIFO is non-empty, else goes to TX_IDLE.
REQ-023 busy = serializer not in TX_IDLE; STATUS reflects FIFO/serializer state of the cycle pready is asserted.

Reset
REQ-024 Reset SHALL immediately force: tx=1, pready=0, prdata=0, bus FSM IDLE, serializer TX_IDLE, FIFO pointers/count 0, bit counter 0.
REQ-025 Reset mid-frame SHALL abort the frame and discard FIFO contents; no partial byte resumes after release.
REQ-026 After release, first access accepted on the first psel=1 sampled.

Configuration
REQ-027 Macro UART_TX_PARITY_EN: when defined, a PARITY state between DATA and STOP sends even parity (XOR of the 8 data bits), frame = 11 bits; when undefined, no PARITY state, frame = 10 bits.
REQ-028 STATUS bit layout SHALL not change with the macro.

Verification
REQ-029 Write 0x55 to 0x0, CLK_DIV=4: pready 1 cycle after psel; tx = 0,1,0,1,0,1,0,1,0,1 each 4 cycles (parity off), then idle high.
REQ-030 FIFO_DEPTH=4, five back-to-back TXDATA writes: writes 1-4 complete in 1 cycle; write 5 stalls with pready=0 until the first pop, then completes.
REQ-031 Read 0x4 while idle -> prdata=0x2; read 0x4 during a frame with 4 bytes queued -> prdata=0x5.
REQ-032 psel held high 10 cycles on one TXDATA write -> exactly one byte pushed, a single pready pulse.
REQ-033 Assert reset mid data bit 3: tx=1 in the same cycle; STATUS after release reads 0x2; no further frames.
REQ-034 UART_TX_PARITY_EN defined, write 0x07 -> parity bit 1 precedes stop; write 0x03 -> parity bit 0.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small transmit FIFO.
// Register map: 0x0 TXDATA (write pushes a byte, read returns 0),
//               0x4 STATUS {29'b0, busy, empty, full}; other offsets read 0.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit between the
// last data bit and the stop bit (11-bit frame instead of 10-bit).
module mmio_uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        tx
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] DIV_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} bus_state_t;
  typedef enum logic [2:0] {TX_IDLE, START, DATA, PARITY, STOP} tx_state_t;

  // bus side
  bus_state_t r_bus_state;
  bus_state_t w_bus_next;
  logic       w_sel_txdata;
  logic       w_sel_status;
  logic       w_push;

  // FIFO
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic [7:0]       w_head;

  // serializer
  tx_state_t  r_tx_state;
  tx_state_t  w_tx_next;
  logic [15:0] r_div_cnt;
  logic [15:0] w_div_next;
  logic [2:0]  r_bit_idx;
  logic [2:0]  w_bit_next;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_next;
  logic        r_parity;
  logic        w_parity_next;
  logic        r_tx;
  logic        w_tx_line_next;
  logic        w_bit_end;
  logic        w_busy;

  // only the low byte of the write bus carries data
  logic w_unused;
  assign w_unused = ^pwdata[31:8];

  assign w_sel_txdata = (paddr == 4'h0);
  assign w_sel_status = (paddr == 4'h4);
  assign w_full       = (r_count == COUNT_FULL);
  assign w_empty      = (r_count == '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_busy       = (r_tx_state != TX_IDLE);
  assign w_bit_end    = (r_div_cnt == 16'd0);
  assign tx           = r_tx;

  // bus FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_bus_state <= IDLE;
    else       r_bus_state <= w_bus_next;
  end

  // bus FSM next state, pready/prdata and FIFO push; a TXDATA write into a
  // full FIFO (full judged before any same-cycle pop) waits in ACCESS
  always_comb begin
    w_bus_next = r_bus_state;
    pready     = 1'b0;
    prdata     = 32'd0;
    w_push     = 1'b0;
    case (r_bus_state)
      IDLE: begin
        if (psel) w_bus_next = ACCESS;
      end
      ACCESS: begin
        if (!(pwrite && w_sel_txdata && w_full)) begin
          pready     = 1'b1;
          w_bus_next = DONE;
          if (pwrite && w_sel_txdata) w_push = 1'b1;
          if (!pwrite && w_sel_status) prdata = {29'd0, w_busy, w_empty, w_full};
        end
      end
      DONE: begin
        if (!psel) w_bus_next = IDLE;
      end
      default: w_bus_next = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because pointers are cleared
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= pwdata[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // serializer state, bit timer, shift register and registered line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_div_cnt  <= 16'd0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_next;
      r_div_cnt  <= w_div_next;
      r_bit_idx  <= w_bit_next;
      r_shift    <= w_shift_next;
      r_parity   <= w_parity_next;
      r_tx       <= w_tx_line_next;
    end
  end

  // serializer next state; the line value is derived from the next state so
  // tx changes exactly on the bit boundary
  always_comb begin
    w_tx_next     = r_tx_state;
    w_div_next    = r_div_cnt;
    w_bit_next    = r_bit_idx;
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    w_pop         = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_next  = w_head;
          w_parity_next = ^w_head;
          w_div_next    = DIV_RELOAD;
          w_tx_next     = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_div_next = DIV_RELOAD;
          w_bit_next = 3'd0;
          w_tx_next  = DATA;
        end else begin
          w_div_next = r_div_cnt - 16'd1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_div_next = DIV_RELOAD;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_tx_next = PARITY;
`else
            w_tx_next = STOP;
`endif
          end else begin
            w_bit_next   = r_bit_idx + 3'd1;
            w_shift_next = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_div_next = r_div_cnt - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_div_next = DIV_RELOAD;
          w_tx_next  = STOP;
        end else begin
          w_div_next = r_div_cnt - 16'd1;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          if (!w_empty) begin
            // back-to-back frames: no idle bit between stop and next start
            w_pop         = 1'b1;
            w_shift_next  = w_head;
            w_parity_next = ^w_head;
            w_div_next    = DIV_RELOAD;
            w_tx_next     = START;
          end else begin
            w_tx_next = TX_IDLE;
          end
        end else begin
          w_div_next = r_div_cnt - 16'd1;
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase

    case (w_tx_next)
      START:   w_tx_line_next = 1'b0;
      DATA:    w_tx_line_next = w_shift_next[0];
      PARITY:  w_tx_line_next = w_parity_next;
      default: w_tx_line_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: table-driven register accesses plus
// hand-written sequences (FIFO stall, held psel, mid-frame reset, parity).
// A serial-line monitor decodes frames and checks them against a scoreboard
// queue filled whenever a TXDATA write completes.
module tb_mmio_uart_tx;

  localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int STOP_IDX = PAR ? 10 : 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        tx;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb[$];

  bit         mon_active = 1'b0;
  int         mon_ph     = 0;

  mmio_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .psel   (psel),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .prdata (prdata),
    .pready (pready),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // one bus transfer, started and finished on a falling edge
  task automatic bus_xfer(input bit wr, input logic [3:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat);
    psel = 1'b1; pwrite = wr; paddr = a; pwdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!pready && lat < 1000);
    rd = prdata;
    if (pready && wr && a == 4'h0) sb.push_back(d[7:0]);
    $display("[TB] xfer %s addr=0x%0h data=0x%0h rdata=0x%0h latency=%0d",
             wr ? "WR" : "RD", a, d, rd, lat);
    @(negedge clk);
    chk("pready_pulse", {31'd0, pready}, 32'd0);
    psel = 1'b0; pwrite = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int cyc = 0;
    while ((sb.size() != 0 || mon_active) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_timeout", {31'd0, cyc >= 3000}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  // serial monitor: samples mid-bit, compares each received byte to the scoreboard
  initial begin : monitor
    logic [7:0] rx;
    int idx;
    rx = 8'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx == 1'b0) begin
          mon_active = 1'b1;
          mon_ph = 0;
        end
      end else begin
        mon_ph++;
        if (mon_ph % CD == CD / 2) begin
          idx = mon_ph / CD;
          if (idx == 0) begin
            chk("start_bit", {31'd0, tx}, 32'd0);
          end else if (idx <= 8) begin
            rx[idx-1] = tx;
          end else if (PAR && idx == 9) begin
            chk("parity_bit", {31'd0, tx}, {31'd0, ^rx});
          end else if (idx == STOP_IDX) begin
            chk("stop_bit", {31'd0, tx}, 32'd1);
            if (sb.size() == 0) begin
              chk("unexpected_frame", {24'd0, rx}, 32'hFFFF_FFFF);
            end else begin
              chk("frame_byte", {24'd0, rx}, {24'd0, sb.pop_front()});
            end
            $display("[TB] frame rx=0x%0h", rx);
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin : stim
    logic [31:0] rd;
    int lat;
    int pulses;
    int low_cycles;
    int cyc;

    vecs[0] = '{1'b0, 4'h4, 32'h0,        32'h2, 1};
    vecs[1] = '{1'b0, 4'h0, 32'h0,        32'h0, 1};
    vecs[2] = '{1'b0, 4'h8, 32'h0,        32'h0, 1};
    vecs[3] = '{1'b1, 4'h8, 32'hAA,       32'h0, 1};
    vecs[4] = '{1'b1, 4'hC, 32'h77,       32'h0, 1};
    vecs[5] = '{1'b0, 4'h4, 32'h0,        32'h2, 1};
    vecs[6] = '{1'b1, 4'h0, 32'h55,       32'h0, 1};
    vecs[7] = '{1'b1, 4'h0, 32'hFFFF_FFA3, 32'h0, 1};
    vecs[8] = '{1'b1, 4'h0, 32'h00,       32'h0, 1};
    vecs[9] = '{1'b1, 4'h0, 32'hFF,       32'h0, 1};

    reset = 1'b1; psel = 1'b0; pwrite = 1'b0; paddr = 4'h0; pwdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_pready", {31'd0, pready}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // register map and single-byte frames
    for (int i = 0; i < 10; i++) begin
      bus_xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end
    drain();
    chk("idle_tx_high", {31'd0, tx}, 32'd1);

    // one frame in flight, then five back-to-back writes: the fifth stalls
    bus_xfer(1'b1, 4'h0, 32'h11, rd, lat);
    chk("burst_w0_lat", lat, 1);
    bus_xfer(1'b1, 4'h0, 32'h22, rd, lat);
    chk("burst_w1_lat", lat, 1);
    bus_xfer(1'b1, 4'h0, 32'h33, rd, lat);
    chk("burst_w2_lat", lat, 1);
    bus_xfer(1'b1, 4'h0, 32'h44, rd, lat);
    chk("burst_w3_lat", lat, 1);
    bus_xfer(1'b1, 4'h0, 32'h66, rd, lat);
    chk("burst_w4_lat", lat, 1);
    bus_xfer(1'b0, 4'h4, 32'h0, rd, lat);
    chk("status_busy_full", rd, 32'h5);
    bus_xfer(1'b1, 4'h0, 32'h99, rd, lat);
    chk("burst_w5_stalled", {31'd0, lat > 1}, 32'd1);
    chk("burst_w5_completes", {31'd0, lat < 100}, 32'd1);
    drain();

    // psel held for ten cycles: a single pready pulse and one byte
    psel = 1'b1; pwrite = 1'b1; paddr = 4'h0; pwdata = 32'h3C;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (pready) pulses++;
    end
    psel = 1'b0; pwrite = 1'b0;
    sb.push_back(8'h3C);
    $display("[TB] held-psel write data=0x3c pulses=%0d", pulses);
    chk("held_psel_pulses", pulses, 1);
    @(negedge clk);
    drain();

`ifdef UART_TX_PARITY_EN
    bus_xfer(1'b1, 4'h0, 32'h07, rd, lat);
    bus_xfer(1'b1, 4'h0, 32'h03, rd, lat);
    drain();
`endif

    // reset in the middle of data bit 3, with a second byte still queued
    bus_xfer(1'b1, 4'h0, 32'hA5, rd, lat);
    bus_xfer(1'b1, 4'h0, 32'h3C, rd, lat);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
    end while (!(mon_active && mon_ph == 4 * CD + 2) && cyc < 1000);
    chk("reach_bit3_timeout", {31'd0, cyc >= 1000}, 32'd0);
    #1;
    chk("bit3_value", {31'd0, tx}, 32'd0);
    reset = 1'b1;
    #1;
    chk("reset_tx_immediate", {31'd0, tx}, 32'd1);
    sb.delete();
    $display("[TB] reset asserted mid-frame");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_xfer(1'b0, 4'h4, 32'h0, rd, lat);
    chk("post_reset_status", rd, 32'h2);
    chk("post_reset_latency", lat, 1);
    low_cycles = 0;
    repeat (100) begin
      @(negedge clk);
      if (!tx) low_cycles++;
    end
    chk("post_reset_line_idle", low_cycles, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
